// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: serial pattern transmitter.
// Shifts a programmable PAT_W-bit pattern out MSB-first, one bit per clock. It sends `rep`
// frames with `gap` idle cycles between them, and every output is registered.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   asynchronous active-low reset
//   pat_ld    in   load pat_in into the pattern register (IDLE only)
//   pat_in    in   new pattern value
//   start     in   begin transmission (IDLE only; abort has priority)
//   rep       in   number of frames, captured at start
//   gap       in   idle cycles between frames, captured at start
//   abort     in   synchronous abort back to IDLE, no done pulse
//   dout      out  serial data bit
//   dvalid    out  dout carries a pattern bit
//   frame_end out  high with the last bit of each frame
//   busy      out  high whenever not IDLE
//   done      out  one-cycle pulse on normal completion
module seq_pattern_tx #(
    parameter int unsigned         PAT_W   = 5,
    parameter logic [PAT_W-1:0]    PAT_DEF = 5'b11011,
    parameter int unsigned         REP_W   = 4,
    parameter int unsigned         GAP_W   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pat_ld,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             start,
    input  logic [REP_W-1:0] rep,
    input  logic [GAP_W-1:0] gap,
    input  logic             abort,
    output logic             dout,
    output logic             dvalid,
    output logic             frame_end,
    output logic             busy,
    output logic             done
);

    localparam int unsigned      IDX_W   = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {StIdle, StSend, StGap, StFin} state_e;

    state_e             state_q, state_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [REP_W-1:0]   rem_q, rem_d;    // frames still to send after the current one
    logic [GAP_W-1:0]   gap_q, gap_d;    // captured gap length
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;  // gap cycles left after the current one
    logic               dout_d, dvalid_d, frame_end_d, busy_d, done_d;

    // Next-state logic. Outputs are derived from the next state so that the registered
    // outputs describe the cycle the FSM is entering (first bit right after the start edge).
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        gap_d   = gap_q;
        gcnt_d  = gcnt_q;

        unique case (state_q)
            StIdle: begin
                if (pat_ld) begin
                    pat_d = pat_in;
                end
                if (start && !abort) begin
                    gap_d  = gap;
                    gcnt_d = '0;
                    if (rep != '0) begin
                        state_d = StSend;
                        idx_d   = IDX_TOP;
                        rem_d   = rep - 1'b1;
                    end else begin
                        state_d = StFin;
                        rem_d   = '0;
                    end
                end
            end
            StSend: begin
                if (idx_q == '0) begin
                    if (rem_q != '0) begin
                        rem_d = rem_q - 1'b1;
                        idx_d = IDX_TOP;
                        if (gap_q != '0) begin
                            state_d = StGap;
                            gcnt_d  = gap_q - 1'b1;
                        end
                    end else begin
                        state_d = StFin;
                    end
                end else begin
                    idx_d = idx_q - 1'b1;
                end
            end
            StGap: begin
                // idx was already reloaded when the gap was entered.
                if (gcnt_q == '0) begin
                    state_d = StSend;
                end else begin
                    gcnt_d = gcnt_q - 1'b1;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d = StIdle;
        end

        dvalid_d    = (state_d == StSend);
        dout_d      = dvalid_d ? pat_d[idx_d] : 1'b0;
        frame_end_d = dvalid_d && (idx_d == '0);
        busy_d      = (state_d != StIdle);
        done_d      = (state_d == StFin);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            pat_q     <= PAT_DEF;
            idx_q     <= '0;
            rem_q     <= '0;
            gap_q     <= '0;
            gcnt_q    <= '0;
            dout      <= 1'b0;
            dvalid    <= 1'b0;
            frame_end <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            idx_q     <= idx_d;
            rem_q     <= rem_d;
            gap_q     <= gap_d;
            gcnt_q    <= gcnt_d;
            dout      <= dout_d;
            dvalid    <= dvalid_d;
            frame_end <= frame_end_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_seq_pattern_tx.sv
module tb_seq_pattern_tx;

    localparam int PAT_W = 5;
    localparam int REP_W = 4;
    localparam int GAP_W = 3;
    localparam logic [PAT_W-1:0] PAT_DEF = 5'b11011;

    logic             clk;
    logic             rst;
    logic             pat_ld;
    logic [PAT_W-1:0] pat_in;
    logic             start;
    logic [REP_W-1:0] rep;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             dout, dvalid, frame_end, busy, done;

    int               n_cmp = 0;
    int               n_err = 0;
    logic [PAT_W-1:0] model_pat;

    seq_pattern_tx #(
        .PAT_W   (PAT_W),
        .PAT_DEF (PAT_DEF),
        .REP_W   (REP_W),
        .GAP_W   (GAP_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pat_ld    (pat_ld),
        .pat_in    (pat_in),
        .start     (start),
        .rep       (rep),
        .gap       (gap),
        .abort     (abort),
        .dout      (dout),
        .dvalid    (dvalid),
        .frame_end (frame_end),
        .busy      (busy),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Expected {dout, dvalid, frame_end, busy, done} in cycle c (1 = cycle after start edge).
    // Frames of PAT_W bits separated by g idle cycles, then one done cycle, then idle.
    function automatic logic [4:0] model(input logic [PAT_W-1:0] p, input int r, input int g,
                                         input int c);
        int len, q;
        logic d, v, f, b, n;
        d = 0; v = 0; f = 0; b = 0; n = 0;
        len = (r == 0) ? 0 : r * PAT_W + (r - 1) * g;
        if (c <= len) begin
            b = 1;
            q = (c - 1) % (PAT_W + g);
            if (q < PAT_W) begin
                d = p[PAT_W-1-q];
                v = 1;
                f = (q == PAT_W - 1);
            end
        end else if (c == len + 1) begin
            b = 1;
            n = 1;
        end
        return {d, v, f, b, n};
    endfunction

    task automatic check_outs(input string tag, input logic [4:0] e);
        check({tag, ".dout"},      dout,      e[4]);
        check({tag, ".dvalid"},    dvalid,    e[3]);
        check({tag, ".frame_end"}, frame_end, e[2]);
        check({tag, ".busy"},      busy,      e[1]);
        check({tag, ".done"},      done,      e[0]);
    endtask

    task automatic load(input logic [PAT_W-1:0] v);
        pat_in = v;
        pat_ld = 1;
        tick();
        pat_ld = 0;
        model_pat = v;
    endtask

    // One full transmission. ld loads newp in the start cycle; noise wiggles start/rep/gap/
    // pat_ld while busy, all of which must be ignored.
    task automatic run(input string name, input bit ld, input logic [PAT_W-1:0] newp,
                       input int r, input int g, input bit noise);
        int len;
        if (ld) begin
            pat_ld = 1;
            pat_in = newp;
            model_pat = newp;
        end
        rep   = REP_W'(r);
        gap   = GAP_W'(g);
        start = 1;
        tick();
        start  = 0;
        pat_ld = 0;
        len = (r == 0) ? 0 : r * PAT_W + (r - 1) * g;
        for (int c = 1; c <= len + 2; c++) begin
            check_outs($sformatf("%s c%0d", name, c), model(model_pat, r, g, c));
            if (noise && c <= len) begin
                start  = 1'($urandom);
                pat_ld = 1'($urandom);
                pat_in = PAT_W'($urandom);
                rep    = REP_W'($urandom);
                gap    = GAP_W'($urandom);
            end else begin
                start  = 0;
                pat_ld = 0;
            end
            tick();
        end
    endtask

    // Start a run and abort it during cycle k; next two cycles must be fully idle.
    task automatic abort_run(input string name, input int r, input int g, input int k);
        rep   = REP_W'(r);
        gap   = GAP_W'(g);
        start = 1;
        tick();
        start = 0;
        for (int c = 1; c <= k; c++) begin
            check_outs($sformatf("%s c%0d", name, c), model(model_pat, r, g, c));
            if (c == k) abort = 1;
            tick();
        end
        abort = 0;
        check_outs($sformatf("%s c%0d", name, k + 1), 5'b00000);
        tick();
        check_outs($sformatf("%s c%0d", name, k + 2), 5'b00000);
    endtask

    initial begin
        rst = 0; pat_ld = 0; pat_in = '0; start = 0; rep = '0; gap = '0; abort = 0;
        model_pat = PAT_DEF;
        #1;
        check_outs("reset", 5'b00000);
        tick();
        rst = 1;
        tick();
        check_outs("post_reset", 5'b00000);

        run("t1_single", 0, '0, 1, 0, 0);
        run("t2_b2b", 0, '0, 2, 0, 0);
        run("t3_gap3", 0, '0, 2, 3, 0);

        load(5'b10110);
        run("t4_loaded", 0, '0, 1, 0, 1);
        run("t4_unchanged", 0, '0, 1, 0, 0);
        run("t4_ld_with_start", 1, 5'b01001, 2, 1, 0);

        abort_run("t5_abort_send", 3, 0, 3);
        abort_run("t5_abort_gap", 2, 3, 6);
        abort_run("t5_abort_fin", 1, 0, 6);
        run("t5_busy_noise", 0, '0, 3, 2, 1);

        // start + abort together: stay idle, but pat_ld still lands.
        start = 1; abort = 1; rep = 4'd3; pat_ld = 1; pat_in = 5'b01101;
        tick();
        start = 0; abort = 0; pat_ld = 0;
        model_pat = 5'b01101;
        check_outs("t5_start_abort", 5'b00000);
        tick();
        check_outs("t5_start_abort2", 5'b00000);
        run("t5_pat_after_abort", 0, '0, 1, 0, 0);

        run("t6_rep0", 0, '0, 0, 5, 0);
        run("t6_max_rep", 0, '0, 15, 7, 1);

        // Asynchronous reset mid-frame, then pattern must be back to default.
        load(5'b10110);
        rep = 4'd2; gap = 3'd0; start = 1;
        tick();
        start = 0;
        tick();
        tick();
        #2;
        rst = 0;
        #1;
        check_outs("t6_async_rst", 5'b00000);
        tick();
        check_outs("t6_in_rst", 5'b00000);
        rst = 1;
        model_pat = PAT_DEF;
        tick();
        run("t6_after_rst", 0, '0, 1, 0, 0);

        for (int i = 0; i < 8; i++) begin
            run($sformatf("rnd%0d", i), 1'($urandom), PAT_W'($urandom),
                int'($urandom_range(0, 15)), int'($urandom_range(0, 7)), 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
Name: seq_pattern_tx

Overview:
- Serial pattern transmitter: shifts a programmable PAT_W-bit pattern out MSB-first, one bit per clock.
- Supports N repetitions, with an optional programmable idle gap between frames.
- Source end of the serial bit-stream link. Its output feeds the team's Mealy overlapping sequence detectors (default pattern 11011) in loopback benches and on-chip self-test.
- Handshake: start/busy/done, plus a per-frame end marker and a synchronous abort.

Parameters:
- PAT_W, 5, pattern length in bits (≥2).
- PAT_DEF, 5'b11011, pattern register value after reset.
- REP_W, 4, width of repetition count.
- GAP_W, 3, width of inter-frame gap count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- pat_ld  in  1  load pat_in into the pattern register; honoured only in IDLE.
- pat_in  in  PAT_W  new pattern value.
- start  in  1  begin transmission; sampled only in IDLE.
- rep  in  REP_W  number of frames to send, captured at start.
- gap  in  GAP_W  idle cycles between frames, captured at start.
- abort  in  1  synchronous abort.
- dout  out  1  serial data bit (registered).
- dvalid  out  1  dout carries a pattern bit this cycle.
- frame_end  out  1  high with the last bit of each frame.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on normal completion.

Behaviour:
- Reset (rst=0, async): state IDLE; pattern register = PAT_DEF; bit index, rep and gap counters = 0. dout=0, dvalid=0, frame_end=0, busy=0, done=0.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, SEND, GAP, FIN.
- IDLE:
  - pat_ld=1 loads pat_in at the edge.
  - start=1 (and abort=0) captures rep and gap into counters.
    - If rep≠0: go to SEND, bit index = PAT_W-1.
    - If rep=0: go to FIN; no bits are sent.
  - pat_ld and start in the same cycle: the new pattern takes effect for this transmission.
- SEND: each cycle, dout = pat[idx] and dvalid=1; idx decrements. When idx=0:
  - frame_end=1 in that same cycle.
  - Frames remaining after this one and gap=0: next cycle restarts at idx=PAT_W-1, back-to-back.
  - Frames remaining and gap>0: go to GAP.
  - Last frame: go to FIN.
- GAP: dout=0, dvalid=0 for exactly gap cycles, then SEND with idx=PAT_W-1.
- FIN: done=1 and busy=1 for one cycle, dout=0, dvalid=0; then IDLE.
- Latency: first bit on dout in the cycle after the start edge.
  - Frame k (1-based) with gap G occupies cycles 1+(k-1)(PAT_W+G) … k·PAT_W+(k-1)G.
  - done appears one cycle after the final bit.
- start while busy: ignored. pat_ld while busy: ignored; the pattern register is unchanged.
- abort=1 in SEND, GAP or FIN: next edge goes to IDLE with all outputs 0; no done pulse.
- abort=1 in IDLE: abort beats start; stay IDLE. pat_ld is still honoured.
- rep and gap input changes mid-transmission have no effect (captured copies are used).
- rst asserted mid-transmission: immediate return to reset values; the pattern reverts to PAT_DEF.
- Maximum rep = 2^REP_W−1. Counters must not wrap.

Test Plan:
1. Reset → outputs all 0, busy=0. Start with rep=1, gap=0, default pattern → dout 1,1,0,1,1 with dvalid=1 on cycles 1–5; frame_end on cycle 5; done on cycle 6; busy high cycles 1–6.
2. rep=2, gap=0 → dout 1101111011 on cycles 1–10; frame_end on cycles 5 and 10; done on cycle 11. In loopback, the 11011 overlapping detector's z pulses on cycles 5 and 10 only.
3. rep=2, gap=3 → bits on cycles 1–5 and 9–13; dvalid=0 and dout=0 on cycles 6–8; done on cycle 14.
4. pat_ld with pat_in=5'b10110 in IDLE, then rep=1 → dout 1,0,1,1,0. pat_ld asserted during that send → pattern register unchanged afterwards.
5. abort asserted on cycle 3 of a rep=3 run → cycle 4 all outputs 0, busy=0, no done. A start while busy is ignored. start+abort together in IDLE → stays IDLE.
6. rep=0 → no dvalid; done on cycle 1. rst pulsed mid-frame → outputs 0 asynchronously; pattern back to 11011.
